// File: rtl/sequnce_cnt_mod.sv
// Sequence counter / phase generator for the ALU control unit.
// Walks a six-phase one-hot sequence: idle, load-1, load-2, then an
// execute/test loop that repeats until the datapath raises END, then a
// single-cycle done phase before returning to idle. Phase strobes are the
// state flops themselves, so the control decode downstream sees no glitches.
module sequnce_cnt_mod (
   input  logic CLK,
   input  logic RST,
   input  logic BGN,
   input  logic END,
   output logic fi0,
   output logic fi1,
   output logic fi2,
   output logic fi3,
   output logic fi4,
   output logic fi5
);

   // One-hot phase encoding; bit n drives strobe fin.
   typedef enum logic [5:0] {
      S_FI0 = 6'b000001,  // idle, waits for BGN
      S_FI1 = 6'b000010,  // first operand load
      S_FI2 = 6'b000100,  // second operand load
      S_FI3 = 6'b001000,  // execute step
      S_FI4 = 6'b010000,  // iteration test, looks at END
      S_FI5 = 6'b100000   // done, lasts one cycle
   } state_t;

   state_t r_state;

   // Phase register: async reset to idle; any illegal pattern (upset or
   // power-up garbage) falls into the default arm and returns to idle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_FI0;
      end else begin
         case (r_state)
            S_FI0:   r_state <= BGN ? S_FI1 : S_FI0;
            S_FI1:   r_state <= S_FI2;
            S_FI2:   r_state <= S_FI3;
            S_FI3:   r_state <= S_FI4;
            S_FI4:   r_state <= END ? S_FI5 : S_FI3;
            S_FI5:   r_state <= S_FI0;
            default: r_state <= S_FI0;
         endcase
      end
   end

   // Strobes are taken directly from the state flops.
   assign fi0 = r_state[0];
   assign fi1 = r_state[1];
   assign fi2 = r_state[2];
   assign fi3 = r_state[3];
   assign fi4 = r_state[4];
   assign fi5 = r_state[5];

endmodule

// File: tb/tb_sequnce_cnt_mod.sv
// Randomized bench for sequnce_cnt_mod against a phase-number reference model.
module tb_sequnce_cnt_mod;

   logic CLK = 1'b0;
   logic RST, BGN, END;
   logic fi0, fi1, fi2, fi3, fi4, fi5;

   int n_vec = 0;
   int n_err = 0;
   int ph    = 0;   // reference phase number 0..5

   sequnce_cnt_mod dut (
      .CLK(CLK), .RST(RST), .BGN(BGN), .END(END),
      .fi0(fi0), .fi1(fi1), .fi2(fi2), .fi3(fi3), .fi4(fi4), .fi5(fi5)
   );

   // 20 ns period, rising edges at 10, 30, 50 ns ...
   always #10 CLK = ~CLK;

   function automatic logic [5:0] phase_vec(input int p);
      logic [5:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   function automatic logic [5:0] outs();
      return {fi5, fi4, fi3, fi2, fi1, fi0};
   endfunction

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b, want %b", tag, $time, got, exp);
      end
   endtask

   // Check the outputs against the model and that exactly one is high.
   task automatic chk_phase(input string tag);
      chk(tag, outs(), phase_vec(ph));
      chk({tag, "_onehot"}, {5'b0, $onehot(outs())}, 6'd1);
   endtask

   // Called at a falling edge: apply inputs, advance one rising edge,
   // update the model, check at the next falling edge.
   task automatic step(input logic b, input logic e, input string tag);
      BGN = b;
      END = e;
      @(posedge CLK);
      case (ph)
         0:       ph = b ? 1 : 0;
         4:       ph = e ? 5 : 3;
         5:       ph = 0;
         default: ph = ph + 1;
      endcase
      @(negedge CLK);
      chk_phase(tag);
   endtask

   // Called at a falling edge: raise RST between edges, span a rising edge
   // with BGN held high, release, and expect idle throughout.
   task automatic reset_mid();
      BGN = 1'b1;
      #3 RST = 1'b1;
      #1 chk("rst_mid_async", outs(), 6'b000001);
      #9 chk("rst_mid_hold", outs(), 6'b000001);
      RST = 1'b0;
      ph = 0;
      @(negedge CLK);
      chk_phase("rst_mid_after");
   endtask

   initial begin
      RST = 1'b0;
      BGN = 1'b0;
      END = 1'b0;

      // Async reset before any well-defined edge, held across the 10 ns edge.
      #5 RST = 1'b1;
      #1 chk("rst_async", outs(), 6'b000001);
      BGN = 1'b1;
      @(negedge CLK);
      chk("rst_hold", outs(), 6'b000001);
      RST = 1'b0;
      ph = 0;

      // Idle hold: BGN low, END pulsing, stay in fi0.
      for (int i = 0; i < 10; i++) step(1'b0, i[0], "idle_hold");

      // Run loop with END low: fi1, fi2, fi3, fi4, fi3, fi4 ...
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "run_loop");

      // Termination: get into fi4, END -> fi5 -> fi0 -> fi1 with BGN high.
      for (int i = 0; i < 4 && ph != 4; i++) step(1'b1, 1'b0, "to_fi4");
      step(1'b1, 1'b1, "term_fi5");
      step(1'b1, 1'b1, "term_fi0");
      step(1'b1, 1'b0, "term_fi1");

      // Ignored inputs: END high during fi1..fi3, BGN toggled.
      step(1'b0, 1'b1, "ign_fi2");
      step(1'b1, 1'b1, "ign_fi3");
      step(1'b0, 1'b0, "ign_fi4");
      step(1'b0, 1'b1, "ign_fi5");
      step(1'b0, 1'b0, "ign_fi0");

      // Reset in the middle of the execute loop, then restart at fi1.
      step(1'b1, 1'b0, "pre_rst");
      for (int i = 0; i < 4 && ph != 3; i++) step(1'b1, 1'b0, "to_fi3");
      reset_mid();
      step(1'b1, 1'b0, "restart_fi1");

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 59) == 0) reset_mid();
         else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
